// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared register-tag widths, issue slots, A-op NOP codes and latency defaults
package cpu_pkg;

    localparam int TAG_W    = 5;
    localparam int NUM_REGS = 32;

    typedef enum logic [1:0] {
        SLOT_A0 = 2'd0,
        SLOT_A1 = 2'd1,
        SLOT_M  = 2'd2,
        SLOT_LS = 2'd3
    } slot_e;

    localparam logic [3:0] AOP_NOP  = 4'b1111;
    localparam logic [3:0] AOP_JMPI = 4'b1101;

    localparam int ALU_LAT_DEF = 1;
    localparam int MUL_LAT_DEF = 2;
    localparam int LD_LAT_DEF  = 3;

    function automatic logic a_op_no_write(input logic [3:0] op);
        return (op == AOP_NOP) || (op == AOP_JMPI);
    endfunction

endpackage

// File: rtl/sb_entry.sv
// rtl/sb_entry.sv - one register's in-flight countdown; busy while nonzero
module sb_entry #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             dec_en,
    input  logic             load_en,
    input  logic [CNT_W-1:0] load_val,
    output logic             busy
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_dec;

    always_comb begin
        cnt_dec = cnt_q;
        if (dec_en && (cnt_q != '0)) begin
            cnt_dec = cnt_q - CNT_W'(1);
        end
        cnt_d = cnt_dec;
        // A new writer never shortens a longer pending result.
        if (load_en && (load_val > cnt_dec)) begin
            cnt_d = load_val;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign busy = (cnt_q != '0);

endmodule

// File: rtl/id_hazard_scoreboard.sv
// rtl/id_hazard_scoreboard.sv - decode-stage RAW scoreboard producing the ID/EX stall
// Optional SB_PERF_CNT_EN adds a saturating stall_cycles hazard counter.
module id_hazard_scoreboard
    import cpu_pkg::*;
#(
    parameter int ALU_LAT = ALU_LAT_DEF,
    parameter int MUL_LAT = MUL_LAT_DEF,
    parameter int LD_LAT  = LD_LAT_DEF,
    parameter int CNT_W   = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          id_valid,
    input  logic          ext_stall,
    input  logic          flush,
    input  logic          a0cnd,
    input  logic          a1cnd,
    input  logic          mcnd,
    input  logic          lscnd,
    input  logic [44:0]   src_tags,
    input  logic [19:0]   rd_tags,
    input  logic [1:0]    a_nop,
    input  logic          m_en,
    input  logic [1:0]    ls_op,
    output logic          stall,
    output logic [31:0]   busy,
`ifdef SB_PERF_CNT_EN
    output logic [15:0]   stall_cycles,
`endif
    output logic          waw_err
);

    logic [TAG_W-1:0]    rd [4];
    logic [CNT_W-1:0]    lat_m1 [4];
    logic [3:0]          we;
    logic [TAG_W-1:0]    src_k;
    logic [NUM_REGS-1:0] busy_w;
    logic                hazard;
    logic                issue;
    logic                waw_hit;
    logic                waw_err_q;
    logic                waw_err_d;

    always_comb begin
        lat_m1[SLOT_A0] = CNT_W'(ALU_LAT - 1);
        lat_m1[SLOT_A1] = CNT_W'(ALU_LAT - 1);
        lat_m1[SLOT_M]  = CNT_W'(MUL_LAT - 1);
        lat_m1[SLOT_LS] = CNT_W'(LD_LAT - 1);
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            rd[i] = rd_tags[(3 - i) * TAG_W +: TAG_W];
        end
    end

    always_comb begin
        hazard = 1'b0;
        src_k  = '0;
        for (int k = 0; k < 9; k++) begin
            src_k = src_tags[k * TAG_W +: TAG_W];
            if ((src_k != '0) && busy_w[src_k]) begin
                hazard = 1'b1;
            end
        end
        hazard = hazard && id_valid;
    end

    assign stall = hazard | ext_stall;
    assign issue = id_valid && !stall && !flush;

    always_comb begin
        we[SLOT_A0] = issue && !a0cnd && !a_nop[1] && (rd[SLOT_A0] != '0);
        we[SLOT_A1] = issue && !a1cnd && !a_nop[0] && (rd[SLOT_A1] != '0);
        we[SLOT_M]  = issue && !mcnd && m_en && (rd[SLOT_M] != '0);
        we[SLOT_LS] = issue && !lscnd && (ls_op == 2'b10) && (rd[SLOT_LS] != '0);
    end

    always_comb begin
        waw_hit = 1'b0;
        for (int i = 0; i < 4; i++) begin
            for (int j = i + 1; j < 4; j++) begin
                if (we[i] && we[j] && (rd[i] == rd[j])) begin
                    waw_hit = 1'b1;
                end
            end
        end
        waw_err_d = waw_hit;
    end

    assign busy_w[0] = 1'b0;

    for (genvar r = 1; r < NUM_REGS; r++) begin : g_entry
        logic             ld_en;
        logic [CNT_W-1:0] ld_val;

        // Slots scanned a0..ls so the highest-priority writer's latency wins.
        always_comb begin
            ld_en  = 1'b0;
            ld_val = '0;
            for (int i = 0; i < 4; i++) begin
                if (we[i] && (rd[i] == TAG_W'(r))) begin
                    ld_en  = 1'b1;
                    ld_val = lat_m1[i];
                end
            end
        end

        sb_entry #(
            .CNT_W   (CNT_W)
        ) u_entry (
            .clk     (clk),
            .rst_n   (rst_n),
            .dec_en  (!ext_stall),
            .load_en (ld_en),
            .load_val(ld_val),
            .busy    (busy_w[r])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            waw_err_q <= 1'b0;
        end else begin
            waw_err_q <= waw_err_d;
        end
    end

    assign waw_err = waw_err_q;
    assign busy    = busy_w;

`ifdef SB_PERF_CNT_EN
    logic [15:0] stall_cycles_q;
    logic [15:0] stall_cycles_d;

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (hazard && (stall_cycles_q != 16'hFFFF)) begin
            stall_cycles_d = stall_cycles_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles_q <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
`endif

endmodule

// File: doc/id_hazard_scoreboard.md
Name: id_hazard_scoreboard

Overview:
Decode-stage hazard unit for the four-slot issue bundle (a0, a1, m, ls); it is the producer of the stall signal that the ID/EX pipeline register consumes.
- Tracks destination tags in flight through EX/MEM with a per-register countdown.
- Combinationally asserts stall when any source tag in the ID bundle targets a register whose result cannot yet be forwarded.
- Tag 5'd0 means "no register" throughout; it is never tracked and never causes a stall.

Parameters:
ALU_LAT, 1, cycles from a0/a1 issue until the result is forwardable to ID (1..4)
MUL_LAT, 2, same for the m slot (1..4)
LD_LAT, 3, same for a load in the ls slot (1..4)
CNT_W, 2, countdown width; must satisfy 2**CNT_W > max latency - 1

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
id_valid  in  1  ID bundle is a real instruction bundle
ext_stall  in  1  external pipeline freeze (memory wait)
flush  in  1  squash the current ID bundle (mispredict)
a0cnd, a1cnd, mcnd, lscnd  in  1 each  slot predicated off (no write)
src_tags  in  45  {a0_R0,a0_R1,a1_R0,a1_R1,m_R0,m_R1,ls_R0,ls_R1,ls_R2} tags, a0_R0 in [44:40]
rd_tags  in  20  {a0_Rd,a1_Rd,m_Rd,ls_Rd} tags, a0_Rd in [19:15]
a_nop  in  2  {a0,a1} opcode is NOP/JMPI (no write)
m_en  in  1  m slot holds a multiply
ls_op  in  2  {load,store}; 00 = none
stall  out  1  freeze IF/ID and ID/EX
busy  out  32  bit r = cnt[r] != 0; bit 0 is always 0
waw_err  out  1  registered; two slots of the issued bundle wrote the same nonzero tag

Behaviour:
- State: cnt[1..31], each CNT_W bits, plus the waw_err flop. No other state.
- Reset (async, rst_n low): all cnt = 0, waw_err = 0. The outputs therefore read stall = ext_stall, busy = 0, waw_err = 0. A reset mid-operation discards all pending entries immediately.
- hazard = id_valid && OR over the 9 source tags s of (s != 0 && cnt[s] != 0).
- stall = hazard | ext_stall. This is combinational, with no latency, and is sampled by ID/EX in the same cycle.
- issue = id_valid && !stall && !flush.
- Slot write enables, qualified by issue:
  - a0 writes if !a0cnd && !a_nop[1] && tag != 0.
  - a1 writes if !a1cnd && !a_nop[0] && tag != 0.
  - m writes if !mcnd && m_en && tag != 0.
  - ls writes only for a load (ls_op == 2'b10) && !lscnd && tag != 0.
- Per-cycle update, in priority order:
  1. ext_stall high: every cnt holds; no issue is possible.
  2. Otherwise every nonzero cnt decrements by 1.
  3. Then, for each writing slot, cnt[tag] = max(decremented value, LAT - 1).
  - A latency of 1 therefore sets 0: a dependent instruction issues on the next cycle through forwarding.
- WAW inside one bundle:
  - Fixed priority ls > m > a1 > a0.
  - The higher-priority slot's latency is used.
  - waw_err is set to 1 on the following cycle and held for exactly one cycle per offending issue.
- flush: the current bundle sets no counters. Counters already set stay and keep draining; this is conservative and only costs stall cycles.
- A source tag that equals a destination tag in the same bundle never stalls; read-before-write within a bundle is architectural.
- Stores read their three sources (including ls_R2) but never set a counter.
- Counters saturate at 0 and never wrap.

Optional Feature:
SB_PERF_CNT_EN
- Defined: adds output stall_cycles [15:0], a saturating count of cycles with hazard=1. It counts hazard only, not ext_stall. Reset value 0; it sticks at 16'hFFFF.
- Undefined: the port and its counter are absent, and behaviour is otherwise identical.

Decomposition:
Shared package cpu_pkg holds:
- TAG_W = 5, NUM_REGS = 32, the slot enum {SLOT_A0, SLOT_A1, SLOT_M, SLOT_LS}.
- The A-op NOP/JMPI opcode constants 4'b1111 and 4'b1101, also used by the ID/EX register.
- The latency defaults.

One sub-module: sb_entry, a single register's countdown. It takes decrement-enable and load-value inputs, outputs busy, and is instantiated 31 times via generate.

Test Plan:
1. Reset, then bundle a0 Rd=3 (ALU_LAT=1), next bundle a1 R0=3 -> stall=0 on both cycles; busy[3] is never 1.
2. Load ls Rd=7 (LD_LAT=3), next bundle m R1=7:
   - stall=1 for 2 cycles, then 0 on the third; busy[7] is 1 for exactly 2 cycles.
   - Repeat with ext_stall=1 for 2 cycles mid-countdown -> stall is held 4 cycles total and cnt[7] is frozen.
3. Load Rd=5 issued with lscnd=1, or as a store (ls_op=01) -> busy[5]=0 and a dependent instruction issues with no stall.
4. One bundle with a0 Rd=9 and m Rd=9 (m_en=1) -> cnt[9]=1 (MUL_LAT-1), waw_err=1 for exactly one cycle, and a dependent instruction stalls 1 cycle.
5. flush=1 on a bundle with a load Rd=12 -> busy stays 0; a prior mult to Rd=4 keeps draining normally.
6. rst_n pulsed low while busy[7]=1 and stall=1 -> busy=0 immediately, stall=0 (ext_stall=0); SB_PERF_CNT_EN build shows stall_cycles=0.
